mem_responder: RTL

//   Memory-side responder for the address register (AR) / data register (DR) bus.

---
 rtl/mem_responder_pkg.sv | 31 +++
 rtl/mem_responder_mem_array.sv | 34 +++
 rtl/mem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the AR/DR memory responder.
//   - default address/data widths and wait-state count
//   - FSM state and operation encodings
//   - wait_load(): the value the wait-state down-counter starts from
package mem_responder_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int DATA_W_DEF      = 16;
  localparam int WAIT_CYCLES_DEF = 2;

  // Wide enough for the full 0..15 wait-state range.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // The counter runs N-1 .. 0 so that WAIT lasts exactly N cycles.
  // With no wait states it is never used; load zero.
  function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
    return (wait_cycles == 0) ? '0 : CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM backing the responder (the mem_array block).
// Storage has no reset so it maps onto block RAM; contents survive REST.
// Read data is registered: dout reflects the address presented at the
// previous rising edge (read-before-write on a same-address write).
//   clk   in   rising-edge clock
//   we    in   write enable
//   addr  in   word address
//   din   in   write data
//   dout  out  registered read data
module mem_responder_mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the AR/DR bus. Captures a read or write request
// with its address and data, waits WAIT_CYCLES cycles, performs the access
// and pulses DONE for one cycle.
//   clk      in   rising-edge clock
//   REST     in   asynchronous active-high reset
//   ADDR_IN  in   address from AR
//   WDATA    in   write data from DR
//   READ     in   read request level, sampled only in IDLE (wins over WRITE)
//   WRITE    in   write request level, sampled only in IDLE
//   BUSY     out  high while in WAIT or ACCESS
//   DONE     out  one-cycle pulse after the access completes
//   RDATA    out  data of the most recent completed read
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for READ/WRITE; also the DONE cycle
// ST_WAIT   | wait states, counter runs down to zero
// ST_ACCESS | single cycle; array write or RDATA load at its closing edge
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              REST,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              READ,
  input  logic              WRITE,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RDATA
);

  localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               NO_WAIT  = (WAIT_CYCLES == 0);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;
  logic              done_q;
  logic              done_d;
  logic [DATA_W-1:0] rdata_q;

  logic              capture;
  logic              rdata_load;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  always_ff @(posedge clk or posedge REST) begin
    if (REST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    rdata_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (READ || WRITE) begin
          capture = 1'b1;
          if (NO_WAIT) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ACCESS: begin
        done_d     = 1'b1;
        state_d    = ST_IDLE;
        mem_we     = (op_q == OP_WRITE);
        rdata_load = (op_q == OP_READ);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge REST) begin
    if (REST) begin
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      if (capture) begin
        addr_q  <= ADDR_IN;
        wdata_q <= WDATA;
        op_q    <= READ ? OP_READ : OP_WRITE;
      end
      if (rdata_load) begin
        rdata_q <= mem_dout;
      end
    end
  end

  // The RAM read is registered, so in IDLE it is fed the live bus address:
  // the word is then already in mem_dout during ACCESS even with no wait
  // states. Once a request is captured the held address takes over.
  assign mem_addr = (state_q == ST_IDLE) ? ADDR_IN : addr_q;

  mem_responder_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (wdata_q),
    .dout (mem_dout)
  );

  assign BUSY  = (state_q != ST_IDLE);
  assign DONE  = done_q;
  assign RDATA = rdata_q;

endmodule
